// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 message packer.
package sha2_pkg;

   localparam int WordByte = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccept = 2'd1,
      StFlush  = 2'd2
   } sha_st_e;

   // Word format consumed by the padding stage: {data, byte mask}.
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  mask;
   } sha_fifo_t;

   typedef enum logic [31:0] {
      NoError                  = 32'h0,
      SwPushMsgWhenShaDisabled = 32'h1,
      SwInvalidMsgMask         = 32'h2
   } sha_err_code_e;

endpackage

// File: rtl/sha2_msg_packer.sv
// Packs 1..4-byte software writes into full 32-bit FIFO words and flushes the
// trailing partial word at message end, tracking the message length in bits.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// StIdle   | no message open; writes are dropped and flagged
// StAccept | message open; writes are appended to the residual / word
// StFlush  | message ended; emitting residual bytes as a partial word
module sha2_msg_packer
   import sha2_pkg::*;
#(
   parameter bit EndianSwap = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sha_en,
   input  logic        hash_start,
   input  logic        hash_process,
   input  logic        msg_valid_i,
   input  logic [31:0] msg_data_i,
   input  logic [3:0]  msg_mask_i,
   output logic        msg_ready_o,
   output logic        fifo_wvalid_o,
   output logic [35:0] fifo_wdata_o,
   input  logic        fifo_wready_i,
   output logic [63:0] message_length_o,
   output logic        err_o,
   output logic        flush_done_o
);

   sha_st_e     r_state, w_state_nxt;
   logic [23:0] r_res_data, w_res_data_nxt;
   logic [1:0]  r_res_cnt, w_res_cnt_nxt;
   logic        r_out_vld, w_out_vld_nxt;
   sha_fifo_t   r_out, w_out_nxt;
   logic [63:0] r_len, w_len_nxt;
   logic        r_err, w_err_nxt;
   logic        r_done, w_done_nxt;
   logic        r_flush_wait, w_flush_wait_nxt;

   logic        w_ready;
   logic        w_wr;
   logic        w_pop;
   logic        w_legal;
   logic [2:0]  w_nbytes;
   logic [2:0]  w_total;
   logic [55:0] w_cat;

   function automatic logic [2:0] f_nbytes(input logic [3:0] m);
      logic [2:0] n;
      case (m)
         4'b0001: n = 3'd1;
         4'b0011: n = 3'd2;
         4'b0111: n = 3'd3;
         4'b1111: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Append the enabled bytes of a write directly above the residual bytes.
   function automatic logic [55:0] f_align(input logic [23:0] res,
                                           input logic [1:0]  cnt,
                                           input logic [31:0] data,
                                           input logic [3:0]  mask);
      logic [31:0] d;
      for (int k = 0; k < WordByte; k++) begin
         d[8*k +: 8] = mask[k] ? data[8*k +: 8] : 8'h00;
      end
      return ({24'h0, d} << {cnt, 3'b000}) | {32'h0, res};
   endfunction

   function automatic logic [3:0] f_lowmask(input logic [1:0] cnt);
      logic [3:0] m;
      case (cnt)
         2'd1:    m = 4'b0001;
         2'd2:    m = 4'b0011;
         2'd3:    m = 4'b0111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] f_bswap(input logic [31:0] d);
      logic [31:0] v;
      for (int k = 0; k < WordByte; k++) begin
         v[8*k +: 8] = d[8*(WordByte-1-k) +: 8];
      end
      return v;
   endfunction

   function automatic logic [3:0] f_mrev(input logic [3:0] m);
      return {m[0], m[1], m[2], m[3]};
   endfunction

   always_comb begin
      w_ready = 1'b1;
      if (sha_en) begin
         if (r_state == StAccept) begin
            w_ready = !r_out_vld | fifo_wready_i;
         end else if (r_state == StFlush) begin
            w_ready = 1'b0;
         end
      end
   end

   assign w_wr     = msg_valid_i & w_ready;
   assign w_pop    = r_out_vld & fifo_wready_i;
   assign w_nbytes = f_nbytes(msg_mask_i);
   assign w_legal  = (w_nbytes != 3'd0);
   assign w_total  = {1'b0, r_res_cnt} + w_nbytes;
   assign w_cat    = f_align(r_res_data, r_res_cnt, msg_data_i, msg_mask_i);

   always_comb begin
      w_state_nxt      = r_state;
      w_res_data_nxt   = r_res_data;
      w_res_cnt_nxt    = r_res_cnt;
      w_out_vld_nxt    = r_out_vld & ~w_pop;
      w_out_nxt        = r_out;
      w_len_nxt        = r_len;
      w_err_nxt        = 1'b0;
      w_done_nxt       = 1'b0;
      w_flush_wait_nxt = r_flush_wait;

      if (!sha_en) begin
         w_state_nxt      = StIdle;
         w_res_data_nxt   = '0;
         w_res_cnt_nxt    = '0;
         w_out_vld_nxt    = 1'b0;
         w_out_nxt        = '0;
         w_len_nxt        = '0;
         w_flush_wait_nxt = 1'b0;
         w_err_nxt        = msg_valid_i;
      end else if (hash_start) begin
         // A write landing on the start pulse belongs to no message.
         w_state_nxt      = StAccept;
         w_res_data_nxt   = '0;
         w_res_cnt_nxt    = '0;
         w_out_vld_nxt    = 1'b0;
         w_len_nxt        = '0;
         w_flush_wait_nxt = 1'b0;
         w_err_nxt        = w_wr;
      end else begin
         case (r_state)
            StIdle: begin
               w_err_nxt = w_wr;
            end
            StAccept: begin
               if (w_wr) begin
                  if (!w_legal) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_len_nxt     = r_len + {58'd0, w_nbytes, 3'b000};
                     w_res_cnt_nxt = w_total[1:0];
                     if (w_total >= 3'd4) begin
                        w_out_nxt.data = w_cat[31:0];
                        w_out_nxt.mask = 4'b1111;
                        w_out_vld_nxt  = 1'b1;
                        w_res_data_nxt = w_cat[55:32];
                     end else begin
                        w_res_data_nxt = w_cat[23:0];
                     end
                  end
               end
               if (hash_process) begin
                  w_state_nxt      = StFlush;
                  w_flush_wait_nxt = 1'b0;
               end
            end
            StFlush: begin
               if (r_flush_wait) begin
                  if (w_pop) begin
                     w_done_nxt       = 1'b1;
                     w_flush_wait_nxt = 1'b0;
                     w_state_nxt      = StIdle;
                  end
               end else if (r_res_cnt == 2'd0) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = StIdle;
               end else if (!r_out_vld | fifo_wready_i) begin
                  w_out_nxt.data   = {8'h00, r_res_data};
                  w_out_nxt.mask   = f_lowmask(r_res_cnt);
                  w_out_vld_nxt    = 1'b1;
                  w_res_data_nxt   = '0;
                  w_res_cnt_nxt    = '0;
                  w_flush_wait_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= StIdle;
         r_res_data   <= '0;
         r_res_cnt    <= '0;
         r_out_vld    <= 1'b0;
         r_out        <= '0;
         r_len        <= '0;
         r_err        <= 1'b0;
         r_done       <= 1'b0;
         r_flush_wait <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_res_data   <= w_res_data_nxt;
         r_res_cnt    <= w_res_cnt_nxt;
         r_out_vld    <= w_out_vld_nxt;
         r_out        <= w_out_nxt;
         r_len        <= w_len_nxt;
         r_err        <= w_err_nxt;
         r_done       <= w_done_nxt;
         r_flush_wait <= w_flush_wait_nxt;
      end
   end

   assign msg_ready_o      = w_ready;
   assign fifo_wvalid_o    = r_out_vld;
   assign fifo_wdata_o     = EndianSwap ? {f_bswap(r_out.data), f_mrev(r_out.mask)} : r_out;
   assign message_length_o = r_len;
   assign err_o            = r_err;
   assign flush_done_o     = r_done;

endmodule

// File: tb/tb_sha2_msg_packer.sv
// Scoreboard bench for sha2_msg_packer: a byte-queue model predicts FIFO words,
// a monitor compares them on every FIFO handshake.
module tb_sha2_msg_packer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sha_en;
   logic        hash_start;
   logic        hash_process;
   logic        msg_valid_i;
   logic [31:0] msg_data_i;
   logic [3:0]  msg_mask_i;
   logic        msg_ready_o;
   logic        fifo_wvalid_o;
   logic [35:0] fifo_wdata_o;
   logic        fifo_wready_i;
   logic [63:0] message_length_o;
   logic        err_o;
   logic        flush_done_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          stall    = 1'b0;

   logic [7:0]  mq[$];
   logic [35:0] expq[$];
   logic [63:0] mlen;
   bit          model_active;

   sha2_msg_packer dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .sha_en           (sha_en),
      .hash_start       (hash_start),
      .hash_process     (hash_process),
      .msg_valid_i      (msg_valid_i),
      .msg_data_i       (msg_data_i),
      .msg_mask_i       (msg_mask_i),
      .msg_ready_o      (msg_ready_o),
      .fifo_wvalid_o    (fifo_wvalid_o),
      .fifo_wdata_o     (fifo_wdata_o),
      .fifo_wready_i    (fifo_wready_i),
      .message_length_o (message_length_o),
      .err_o            (err_o),
      .flush_done_o     (flush_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: a message is a byte stream; every 4 bytes form a word.
   function automatic int nbytes(input logic [3:0] m);
      case (m)
         4'b0001: return 1;
         4'b0011: return 2;
         4'b0111: return 3;
         4'b1111: return 4;
         default: return 0;
      endcase
   endfunction

   task automatic model_write(input logic [31:0] d, input logic [3:0] m);
      int n;
      logic [31:0] w;
      n = nbytes(m);
      for (int k = 0; k < n; k++) mq.push_back(d[8*k +: 8]);
      mlen = mlen + 64'(8 * n);
      while (mq.size() >= 4) begin
         w = {mq[3], mq[2], mq[1], mq[0]};
         repeat (4) void'(mq.pop_front());
         expq.push_back({w, 4'hF});
      end
   endtask

   task automatic model_flush();
      int r;
      logic [31:0] w;
      r = mq.size();
      if (r > 0) begin
         w = '0;
         for (int k = 0; k < r; k++) w[8*k +: 8] = mq[k];
         expq.push_back({w, 4'((1 << r) - 1)});
      end
      mq.delete();
   endtask

   task automatic model_clear();
      mq.delete();
      expq.delete();
      mlen = '0;
   endtask

   // FIFO-side monitor.
   initial begin
      logic        prev_hold;
      logic [35:0] prev_word;
      logic [35:0] e;
      prev_hold = 1'b0;
      prev_word = '0;
      forever begin
         @(negedge clk_i);
         if (prev_hold && !rst_i && sha_en) begin
            check("hold_valid", fifo_wvalid_o, 1);
            check("hold_data", fifo_wdata_o, prev_word);
         end
         if (fifo_wvalid_o && fifo_wready_i) begin
            if (expq.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %h expected no word", fifo_wdata_o);
            end else begin
               e = expq.pop_front();
               check("fifo_word", fifo_wdata_o, e);
            end
         end
         prev_hold = fifo_wvalid_o && !fifo_wready_i;
         prev_word = fifo_wdata_o;
      end
   end

   initial begin
      fifo_wready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         fifo_wready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_msg();
      step();
      hash_start = 1'b1;
      step();
      hash_start = 1'b0;
      model_clear();
      model_active = sha_en;
   endtask

   task automatic drive_write(input logic [31:0] d, input logic [3:0] m);
      msg_valid_i = 1'b1;
      msg_data_i  = d;
      msg_mask_i  = m;
   endtask

   task automatic finish_write(input bit with_proc);
      bit acc;
      bit exp_err;
      acc = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk_i);
         if (msg_ready_o) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL write_accept: got no ready expected ready within 300 cycles");
         msg_valid_i = 1'b0;
         return;
      end
      if (with_proc) hash_process = 1'b1;
      exp_err = !sha_en || !model_active || (nbytes(msg_mask_i) == 0);
      step();
      msg_valid_i  = 1'b0;
      hash_process = 1'b0;
      check("err_pulse", err_o, exp_err);
      if (!exp_err) model_write(msg_data_i, msg_mask_i);
   endtask

   task automatic wr(input logic [31:0] d, input logic [3:0] m);
      drive_write(d, m);
      finish_write(1'b0);
   endtask

   task automatic do_flush(input bit already);
      int r;
      int tseen;
      bit seen;
      if (!already) begin
         hash_process = 1'b1;
         step();
         hash_process = 1'b0;
      end
      r = mq.size();
      model_flush();
      seen  = 1'b0;
      tseen = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk_i);
         if (flush_done_o) begin
            seen  = 1'b1;
            tseen = t;
            break;
         end
      end
      check("flush_done_seen", seen, 1);
      if (seen && r == 0) check("flush_empty_latency", tseen, 1);
      if (seen && r > 0) begin
         check("flush_after_handoff_q", expq.size(), 0);
         check("flush_after_handoff_v", fifo_wvalid_o, 0);
      end
      if (seen) begin
         @(negedge clk_i);
         check("flush_done_width", flush_done_o, 0);
      end
      for (int t = 0; t < 300 && !(expq.size() == 0 && !fifo_wvalid_o); t++) @(negedge clk_i);
      check("drain", expq.size(), 0);
      check("length", message_length_o, mlen);
      model_active = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  mk;
      int          nw;
      bit          pr;
      rst_i        = 1'b1;
      sha_en       = 1'b0;
      hash_start   = 1'b0;
      hash_process = 1'b0;
      msg_valid_i  = 1'b0;
      msg_data_i   = '0;
      msg_mask_i   = '0;
      model_active = 1'b0;
      mlen         = '0;
      repeat (3) @(negedge clk_i);
      check("rst_wvalid", fifo_wvalid_o, 0);
      check("rst_wdata", fifo_wdata_o, 0);
      check("rst_len", message_length_o, 0);
      check("rst_err", err_o, 0);
      check("rst_done", flush_done_o, 0);
      check("rst_ready", msg_ready_o, 1);
      step();
      rst_i  = 1'b0;
      sha_en = 1'b1;

      // Four full words.
      start_msg();
      repeat (4) wr(32'h03020100, 4'hF);
      do_flush(1'b0);
      check("len_128", message_length_o, 64'd128);

      // 1-byte then 3-byte write assemble one word.
      start_msg();
      wr(32'h000000AA, 4'b0001);
      wr(32'h00CCBBDD, 4'b0111);
      do_flush(1'b0);
      check("len_32", message_length_o, 64'd32);

      // Partial flush.
      start_msg();
      wr(32'h00002211, 4'b0011);
      do_flush(1'b0);
      check("len_16", message_length_o, 64'd16);

      // Write and hash_process in the same cycle.
      start_msg();
      wr(32'h11223344, 4'hF);
      drive_write(32'h00005566, 4'b0011);
      finish_write(1'b1);
      do_flush(1'b1);
      check("len_48", message_length_o, 64'd48);

      // Backpressure: output stalled for 10 cycles.
      start_msg();
      stall = 1'b1;
      step();
      step();
      wr(32'h44332211, 4'hF);
      drive_write(32'h88776655, 4'hF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("stall_ready", msg_ready_o, 0);
         check("stall_valid", fifo_wvalid_o, 1);
         if (expq.size() > 0) check("stall_word", fifo_wdata_o, expq[0]);
      end
      stall = 1'b0;
      finish_write(1'b0);
      wr(32'hCCBBAA99, 4'hF);
      do_flush(1'b0);
      check("len_96", message_length_o, 64'd96);

      // Illegal mask, then a write while disabled.
      start_msg();
      wr(32'h00000011, 4'b0001);
      wr(32'h00990099, 4'b0101);
      step();
      check("len_after_illegal", message_length_o, 64'd8);
      sha_en = 1'b0;
      model_clear();
      model_active = 1'b0;
      step();
      wr(32'h12345678, 4'hF);
      check("len_disabled", message_length_o, 64'd0);
      check("wvalid_disabled", fifo_wvalid_o, 0);
      sha_en = 1'b1;
      step();
      wr(32'h0000BEEF, 4'b0011);

      // Randomized messages.
      for (int m = 0; m < 25; m++) begin
         nw = $urandom_range(0, 10);
         start_msg();
         pr = 1'b0;
         for (int i = 0; i < nw; i++) begin
            d = $urandom;
            case ($urandom_range(0, 11))
               0:       mk = 4'b0101;
               1:       mk = 4'b0000;
               2, 3:    mk = 4'b0001;
               4, 5:    mk = 4'b0011;
               6, 7:    mk = 4'b0111;
               default: mk = 4'b1111;
            endcase
            pr = (i == nw - 1) && ($urandom_range(0, 2) == 0);
            drive_write(d, mk);
            finish_write(pr);
         end
         do_flush(pr);
      end

      // Reset while two bytes sit in the residual.
      start_msg();
      wr(32'h0000BEEF, 4'b0011);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_wvalid", fifo_wvalid_o, 0);
      check("midrst_len", message_length_o, 0);
      check("midrst_ready", msg_ready_o, 1);
      step();
      rst_i = 1'b0;
      model_clear();
      model_active = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         check("postrst_wvalid", fifo_wvalid_o, 0);
      end
      wr(32'h01020304, 4'hF);
      check("postrst_len", message_length_o, 0);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
